// File: rtl/switch_input_conditioner.sv
// Switch front end: per-bit synchroniser, debounce filter, edge pulses and a sticky event register.
// Define SWITCH_COND_FALL_EVENT_EN to also accumulate falling edges into event_bits.
module switch_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch_raw,
    output logic [WIDTH-1:0] switch_stable,
    output logic [WIDTH-1:0] switch_rise,
    output logic [WIDTH-1:0] switch_fall,
    output logic             event_valid,
    output logic [WIDTH-1:0] event_bits,
    input  logic             event_ack
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] event_bits_q;
    logic [WIDTH-1:0] event_bits_d;
    logic [WIDTH-1:0] event_term;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic [CW-1:0]          cnt_q;
            logic [CW-1:0]          cnt_d;
            logic                   stable_q;
            logic                   stable_d;
            logic                   rise_q;
            logic                   rise_d;
            logic                   fall_q;
            logic                   fall_d;
            logic                   synced;

            // Any sample agreeing with the current level restarts the count, so only
            // DEBOUNCE_CYCLES consecutive disagreeing samples move stable.
            always_comb begin
                sync_d   = {sync_q[SYNC_STAGES-2:0], switch_raw[gi]};
                synced   = sync_q[SYNC_STAGES-1];
                cnt_d    = '0;
                stable_d = stable_q;
                if (synced != stable_q) begin
                    if (cnt_q == CNT_MAX) begin
                        stable_d = synced;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                rise_d = stable_d & ~stable_q;
                fall_d = ~stable_d & stable_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q   <= '0;
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                    rise_q   <= 1'b0;
                    fall_q   <= 1'b0;
                end else begin
                    sync_q   <= sync_d;
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                    rise_q   <= rise_d;
                    fall_q   <= fall_d;
                end
            end

            assign switch_stable[gi] = stable_q;
            assign switch_rise[gi]   = rise_q;
            assign switch_fall[gi]   = fall_q;
        end
    endgenerate

`ifdef SWITCH_COND_FALL_EVENT_EN
    assign event_term = switch_rise | switch_fall;
`else
    assign event_term = switch_rise;
`endif

    // An edge reported in the ack cycle survives the clear.
    always_comb begin
        event_bits_d = event_bits_q | event_term;
        if (event_ack) begin
            event_bits_d = event_term;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            event_bits_q <= '0;
        end else begin
            event_bits_q <= event_bits_d;
        end
    end

    assign event_bits  = event_bits_q;
    assign event_valid = |event_bits_q;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Self-checking bench for switch_input_conditioner: directed scenarios plus randomized
// stimulus against a sliding-window reference model.
module tb_switch_input_conditioner;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] switch_raw = '0;
    logic         event_ack = 1'b0;
    logic [W-1:0] switch_stable;
    logic [W-1:0] switch_rise;
    logic [W-1:0] switch_fall;
    logic         event_valid;
    logic [W-1:0] event_bits;

    int errors = 0;
    int checks = 0;

    // Reference model state: raw sample history, synchronised sample window, outputs.
    logic [W-1:0] raw_hist [S];
    logic [W-1:0] syn_hist [D];
    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic [W-1:0] m_ev = '0;

    switch_input_conditioner #(
        .WIDTH(W),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .switch_raw(switch_raw),
        .switch_stable(switch_stable),
        .switch_rise(switch_rise),
        .switch_fall(switch_fall),
        .event_valid(event_valid),
        .event_bits(event_bits),
        .event_ack(event_ack)
    );

    always #5 clk = ~clk;

    // One clock edge: update the model from the inputs sampled at that edge, then settle.
    // A bit's level flips once the last D synchronised samples all disagree with it.
    task automatic tick();
        logic [W-1:0] raw_s;
        logic [W-1:0] synced;
        logic [W-1:0] new_st;
        logic [W-1:0] term;
        logic         rst_s;
        logic         ack_s;
        bit           all_diff;
        @(posedge clk);
        raw_s = switch_raw;
        rst_s = reset;
        ack_s = event_ack;
        if (rst_s) begin
            for (int k = 0; k < S; k++) raw_hist[k] = '0;
            for (int k = 0; k < D; k++) syn_hist[k] = '0;
            m_stable = '0;
            m_rise   = '0;
            m_fall   = '0;
            m_ev     = '0;
        end else begin
            synced = raw_hist[S-1];
            for (int k = S - 1; k > 0; k--) raw_hist[k] = raw_hist[k-1];
            raw_hist[0] = raw_s;
            for (int k = D - 1; k > 0; k--) syn_hist[k] = syn_hist[k-1];
            syn_hist[0] = synced;
            new_st = m_stable;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (syn_hist[k][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) new_st[b] = ~m_stable[b];
            end
`ifdef SWITCH_COND_FALL_EVENT_EN
            term = m_rise | m_fall;
`else
            term = m_rise;
`endif
            m_ev     = ack_s ? term : (m_ev | term);
            m_rise   = new_st & ~m_stable;
            m_fall   = ~new_st & m_stable;
            m_stable = new_st;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1;
        switch_raw = '0;
        ticks(3);
        checks++;
        if (switch_stable !== 8'h00 || switch_rise !== 8'h00 || switch_fall !== 8'h00 ||
            event_bits !== 8'h00 || event_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: stable=%h rise=%h fall=%h ev=%h valid=%b required all 0",
                     switch_stable, switch_rise, switch_fall, event_bits, event_valid);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (switch_stable !== 8'h00 || switch_rise !== 8'h00 || switch_fall !== 8'h00 ||
                event_valid !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL idle_hold cyc %0d: stable=%h rise=%h fall=%h valid=%b required 0",
                         i, switch_stable, switch_rise, switch_fall, event_valid);
            end
        end
        $display("test_reset: done, %0d idle cycles off", bad);
    endtask

    task automatic test_single_rise();
        switch_raw = 8'h01;
        ticks(S + D - 1);
        checks++;
        if (switch_stable !== 8'h00) begin
            errors++;
            $display("FAIL rise_early: stable=%h required 00 at edge %0d", switch_stable, S + D - 1);
        end
        tick();
        checks++;
        if (switch_stable !== 8'h01 || switch_rise !== 8'h01 || switch_fall !== 8'h00) begin
            errors++;
            $display("FAIL rise_edge18: stable=%h rise=%h fall=%h required 01 01 00",
                     switch_stable, switch_rise, switch_fall);
        end
        tick();
        checks++;
        if (switch_rise !== 8'h00 || event_bits !== 8'h01 || event_valid !== 1'b1) begin
            errors++;
            $display("FAIL rise_event: rise=%h ev=%h valid=%b required 00 01 1",
                     switch_rise, event_bits, event_valid);
        end
        ticks(5);
        checks++;
        if (event_bits !== 8'h01 || event_valid !== 1'b1) begin
            errors++;
            $display("FAIL event_sticky: ev=%h valid=%b required 01 1", event_bits, event_valid);
        end
        $display("test_single_rise: stable=%h ev=%h", switch_stable, event_bits);
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        switch_raw = 8'h09;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) switch_raw = 8'h01;
            tick();
            checks++;
            if (switch_stable !== 8'h01 || switch_rise !== 8'h00 || event_bits !== 8'h01) begin
                errors++;
                bad++;
                $display("FAIL glitch cyc %0d: stable=%h rise=%h ev=%h required 01 00 01",
                         i, switch_stable, switch_rise, event_bits);
            end
        end
        $display("test_glitch: 10-cycle pulse on bit 3, %0d cycles off", bad);
    endtask

    task automatic test_ack_edge();
        switch_raw = 8'h21;
        ticks(S + D);
        checks++;
        if (switch_rise !== 8'h20 || switch_stable !== 8'h21 || event_bits !== 8'h01) begin
            errors++;
            $display("FAIL ack_setup: rise=%h stable=%h ev=%h required 20 21 01",
                     switch_rise, switch_stable, event_bits);
        end
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        checks++;
        if (event_bits !== 8'h20 || event_valid !== 1'b1) begin
            errors++;
            $display("FAIL ack_same_cycle_edge: ev=%h valid=%b required 20 1", event_bits, event_valid);
        end
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        checks++;
        if (event_bits !== 8'h00 || event_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: ev=%h valid=%b required 00 0", event_bits, event_valid);
        end
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        checks++;
        if (event_bits !== 8'h00 || event_valid !== 1'b0 || switch_stable !== 8'h21) begin
            errors++;
            $display("FAIL ack_noop: ev=%h valid=%b stable=%h required 00 0 21",
                     event_bits, event_valid, switch_stable);
        end
        $display("test_ack_edge: ev=%h", event_bits);
    endtask

    task automatic test_all_fall();
        logic [W-1:0] exp_ev;
`ifdef SWITCH_COND_FALL_EVENT_EN
        exp_ev = 8'hFF;
`else
        exp_ev = 8'h00;
`endif
        switch_raw = 8'hFF;
        ticks(S + D + 3);
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        ticks(2);
        checks++;
        if (switch_stable !== 8'hFF || event_bits !== 8'h00) begin
            errors++;
            $display("FAIL fall_setup: stable=%h ev=%h required FF 00", switch_stable, event_bits);
        end
        switch_raw = 8'h00;
        ticks(S + D - 1);
        checks++;
        if (switch_stable !== 8'hFF || switch_fall !== 8'h00) begin
            errors++;
            $display("FAIL fall_early: stable=%h fall=%h required FF 00", switch_stable, switch_fall);
        end
        tick();
        checks++;
        if (switch_stable !== 8'h00 || switch_fall !== 8'hFF || switch_rise !== 8'h00) begin
            errors++;
            $display("FAIL fall_edge: stable=%h fall=%h rise=%h required 00 FF 00",
                     switch_stable, switch_fall, switch_rise);
        end
        tick();
        checks++;
        if (switch_fall !== 8'h00 || event_bits !== exp_ev) begin
            errors++;
            $display("FAIL fall_event: fall=%h ev=%h required 00 %h", switch_fall, event_bits, exp_ev);
        end
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        $display("test_all_fall: fall events expected %h", exp_ev);
    endtask

    task automatic test_reset_mid();
        switch_raw = 8'h80;
        ticks(S + 10);
        reset = 1'b1;
        tick();
        checks++;
        if (switch_stable !== 8'h00 || switch_rise !== 8'h00 || event_bits !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: stable=%h rise=%h ev=%h required 00 00 00",
                     switch_stable, switch_rise, event_bits);
        end
        reset = 1'b0;
        ticks(S + D - 1);
        checks++;
        if (switch_stable !== 8'h00 || switch_rise !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_early: stable=%h rise=%h required 00 00", switch_stable, switch_rise);
        end
        tick();
        checks++;
        if (switch_stable !== 8'h80 || switch_rise !== 8'h80) begin
            errors++;
            $display("FAIL mid_reset_rise: stable=%h rise=%h required 80 80", switch_stable, switch_rise);
        end
        tick();
        checks++;
        if (event_bits !== 8'h80 || event_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_event: ev=%h valid=%b required 80 1", event_bits, event_valid);
        end
        $display("test_reset_mid: bit 7 restarted after reset");
    endtask

    task automatic test_random();
        int shown;
        int bad;
        shown = 0;
        for (int blk = 0; blk < 20; blk++) begin
            bad = 0;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) < 10)
                    switch_raw[$urandom_range(0, W - 1)] ^= 1'b1;
                if ($urandom_range(0, 99) < 2)
                    switch_raw = W'($urandom);
                event_ack = ($urandom_range(0, 15) == 0);
                reset = ($urandom_range(0, 599) == 0);
                tick();
                checks++;
                if (switch_stable !== m_stable || switch_rise !== m_rise || switch_fall !== m_fall ||
                    event_bits !== m_ev || event_valid !== (|m_ev)) begin
                    errors++;
                    bad++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL random blk %0d cyc %0d: got st=%h r=%h f=%h ev=%h v=%b want st=%h r=%h f=%h ev=%h v=%b",
                                 blk, i, switch_stable, switch_rise, switch_fall, event_bits, event_valid,
                                 m_stable, m_rise, m_fall, m_ev, |m_ev);
                    end
                end
            end
            $display("test_random block %0d: raw=%h stable=%h ev=%h, %0d cycles off",
                     blk, switch_raw, switch_stable, event_bits, bad);
        end
        event_ack = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_ack_edge();
        test_all_fall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
